ws2812_multi_tx: RTL
====================

Name: ws2812_multi_tx

Overview:
Parametrised successor to the single-strip WS2812 serialiser. It drives NUM_CH strips in lockstep from one pixel stream, with runtime LED count, per-channel enable, and optional 32-bit RGBW pixels. It adds gapless pixel chaining, underrun detection and explicit frame start/done handshakes. It sits between the pixel controller (fed by the UART/FIFO path) and the strip data pins.

Parameters:
NUM_CH, 4, number of parallel strip outputs (1..16)
BITS_PER_PIX, 24, bits per pixel per channel; 24 (GRB) or 32 (GRBW); sent MSB first, no reordering
T_BIT, 63, clk cycles per bit (1.26 us at 50 MHz)
T0H, 20, high cycles for a 0 bit
T1H, 40, high cycles for a 1 bit
RESET_CLKS, 15000, low latch cycles ending a frame (300 us)
UNDERRUN_CLKS, 2000, max low wait for a mid-frame pixel before abort

Ports:
clk  input  1  system clock, all logic rising-edge
rst  input  1  synchronous, active-high reset
start  input  1  one-cycle frame request; honoured only when busy=0
num_leds  input  12  pixels per channel this frame; sampled on accepted start
ch_en  input  NUM_CH  channel enable mask; sampled on accepted start
pix_valid  input  1  pix_data valid
pix_ready  output  1  block accepts pix_data this cycle (transfer = valid & ready)
pix_data  input  NUM_CH*BITS_PER_PIX  channel c at [c*BITS_PER_PIX +: BITS_PER_PIX]
data  output  NUM_CH  strip data lines
busy  output  1  frame in progress
frame_done  output  1  one-cycle pulse at frame end
underrun  output  1  sticky abort flag, cleared on next accepted start

Behaviour:
- Reset: state IDLE; data=0, pix_ready=0, busy=0, frame_done=0, underrun=0; counters cleared. Reset mid-bit forces all lines low on the next edge.
- Parameter rule: 0<T0H<T1H<T_BIT; BITS_PER_PIX in {24,32}.
- States: IDLE, WAIT, BIT, LATCH.
- IDLE: start → latch num_leds/ch_en, clear underrun, busy=1. Next state is WAIT, or LATCH if num_leds=0. start while busy=1 is ignored.
- WAIT: pix_ready=1, data=0.
  - On transfer: load shift regs, decrement remaining count, go to BIT.
  - Wait counter increments each cycle without transfer. When it reaches UNDERRUN_CLKS: underrun=1, go to LATCH, no further pixels accepted.
- BIT: each bit lasts exactly T_BIT cycles.
  - Enabled channel c: data[c]=1 for cycles 0..TxH-1 of the bit (T1H if current bit is 1, else T0H), then 0 for the rest.
  - Disabled channels hold 0 for the whole frame.
  - Bits go MSB first, BITS_PER_PIX bits per pixel.
- Chaining: during the final cycle of a pixel's last bit, pix_ready=1 if pixels remain.
  - Transfer in that cycle: the next pixel's first high phase starts the following cycle (no gap).
  - No transfer: go to WAIT, lines low.
  - No pixels remain: go to LATCH.
- Data first goes high the cycle after the accepting transfer.
- LATCH: all lines low, pix_ready=0 for exactly RESET_CLKS cycles. Next cycle: frame_done=1 for one cycle, busy=0, state IDLE. start is accepted again from that cycle.
- Widths: bit-phase counter $clog2(T_BIT); bit index $clog2(BITS_PER_PIX); LED counter 12 bits; latch/wait counter sized for max(RESET_CLKS, UNDERRUN_CLKS).
- pix_data is held internally after transfer; upstream may change it freely.

Test Plan:
1. NUM_CH=2, num_leds=1, ch_en=2'b11, pix_data={24'h000001, 24'h800001} → ch0 bit23 high 40 / low 23, bits22..1 high 20 each, bit0 high 40. ch1: 23 short pulses then one long. Then 15000 low cycles, then frame_done pulse and busy=0.
2. num_leds=3, pix_valid held high → exactly 3*24*63=4536 cycles from first rising edge to LATCH entry, no idle gaps; pix_ready high one cycle per pixel.
3. num_leds=2, second pixel withheld → lines low, underrun=1 after 2000 wait cycles, then LATCH 15000, frame_done. A pixel offered afterwards is not accepted. Next start clears underrun.
4. ch_en=2'b01 with nonzero ch1 data → data[1]=0 for the entire frame; ch0 waveform unchanged.
5. num_leds=0 → pix_ready never asserted, 15000 low cycles, frame_done. Second start pulse during LATCH is ignored (single frame_done).
6. BITS_PER_PIX=32, pixel 32'hFFFFFFFF → 32 long pulses. rst asserted at cycle 10 of bit 5 → data=0 and busy=0 next cycle, no frame_done.

Source files
------------

// File: rtl/ws2812_multi_tx.sv
// ws2812_multi_tx: multi-channel WS2812 serialiser.
// Drives NUM_CH strips in lockstep from one pixel stream. Each accepted pixel word carries one
// BITS_PER_PIX-bit pixel per channel, sent MSB first. Pixels chain without gaps when offered in
// time; a mid-frame pixel that does not arrive within UNDERRUN_CLKS aborts the frame.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   start      one-cycle frame request, honoured only when idle
//   num_leds   pixels per channel for this frame, sampled on accepted start
//   ch_en      channel enable mask, sampled on accepted start
//   pix_valid  pix_data valid
//   pix_ready  block accepts pix_data this cycle
//   pix_data   channel c at [c*BITS_PER_PIX +: BITS_PER_PIX]
//   data       strip data lines
//   busy       frame in progress
//   frame_done one-cycle pulse at frame end
//   underrun   sticky abort flag, cleared on next accepted start
module ws2812_multi_tx #(
    parameter int unsigned NUM_CH        = 4,
    parameter int unsigned BITS_PER_PIX  = 24,
    parameter int unsigned T_BIT         = 63,
    parameter int unsigned T0H           = 20,
    parameter int unsigned T1H           = 40,
    parameter int unsigned RESET_CLKS    = 15000,
    parameter int unsigned UNDERRUN_CLKS = 2000
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [11:0]                    num_leds,
    input  logic [NUM_CH-1:0]              ch_en,
    input  logic                           pix_valid,
    output logic                           pix_ready,
    input  logic [NUM_CH*BITS_PER_PIX-1:0] pix_data,
    output logic [NUM_CH-1:0]              data,
    output logic                           busy,
    output logic                           frame_done,
    output logic                           underrun
);

    localparam int unsigned PhW    = (T_BIT > 1) ? $clog2(T_BIT) : 1;
    localparam int unsigned BiW    = (BITS_PER_PIX > 1) ? $clog2(BITS_PER_PIX) : 1;
    localparam int unsigned CntMax = (RESET_CLKS > UNDERRUN_CLKS) ? RESET_CLKS : UNDERRUN_CLKS;
    localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;

    localparam logic [PhW-1:0]  PhLast    = PhW'(T_BIT - 1);
    localparam logic [PhW-1:0]  T0hCnt    = PhW'(T0H);
    localparam logic [PhW-1:0]  T1hCnt    = PhW'(T1H);
    localparam logic [BiW-1:0]  BitLast   = BiW'(BITS_PER_PIX - 1);
    localparam logic [CntW-1:0] LatchLast = CntW'(RESET_CLKS - 1);
    localparam logic [CntW-1:0] WaitLast  = CntW'(UNDERRUN_CLKS - 1);

    typedef enum logic [1:0] {StIdle, StWait, StBit, StLatch} state_e;
    typedef logic [NUM_CH-1:0][BITS_PER_PIX-1:0] shift_t;

    state_e         state_q, state_d;
    logic [11:0]    leds_q, leds_d;      // pixels still to be accepted
    logic [NUM_CH-1:0] en_q, en_d;
    shift_t         shift_q, shift_d;    // MSB is the bit currently on the wire
    logic [PhW-1:0] phase_q, phase_d;
    logic [BiW-1:0] bit_q, bit_d;
    logic [CntW-1:0] cnt_q, cnt_d;       // shared wait / latch counter
    logic           underrun_q, underrun_d;
    logic           done_q, done_d;

    logic bit_end, pix_end, xfer;

    always_comb begin
        bit_end   = (state_q == StBit) && (phase_q == PhLast);
        pix_end   = bit_end && (bit_q == BitLast);
        // Offer the next pixel during the final cycle of the current one so it chains gaplessly.
        pix_ready = (state_q == StWait) || (pix_end && (leds_q != 12'd0));
        xfer      = pix_valid && pix_ready;
    end

    always_comb begin
        state_d    = state_q;
        leds_d     = leds_q;
        en_d       = en_q;
        shift_d    = shift_q;
        phase_d    = phase_q;
        bit_d      = bit_q;
        cnt_d      = cnt_q;
        underrun_d = underrun_q;
        done_d     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    leds_d     = num_leds;
                    en_d       = ch_en;
                    underrun_d = 1'b0;
                    cnt_d      = '0;
                    state_d    = (num_leds == 12'd0) ? StLatch : StWait;
                end
            end
            StWait: begin
                if (xfer) begin
                    shift_d = pix_data;
                    leds_d  = leds_q - 12'd1;
                    phase_d = '0;
                    bit_d   = '0;
                    state_d = StBit;
                end else if (cnt_q == WaitLast) begin
                    underrun_d = 1'b1;
                    cnt_d      = '0;
                    state_d    = StLatch;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StBit: begin
                if (!bit_end) begin
                    phase_d = phase_q + 1'b1;
                end else if (!pix_end) begin
                    phase_d = '0;
                    bit_d   = bit_q + 1'b1;
                    for (int c = 0; c < int'(NUM_CH); c++) begin
                        shift_d[c] = {shift_q[c][BITS_PER_PIX-2:0], 1'b0};
                    end
                end else if (xfer) begin
                    shift_d = pix_data;
                    leds_d  = leds_q - 12'd1;
                    phase_d = '0;
                    bit_d   = '0;
                end else begin
                    cnt_d   = '0;
                    state_d = (leds_q != 12'd0) ? StWait : StLatch;
                end
            end
            StLatch: begin
                if (cnt_q == LatchLast) begin
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            leds_q     <= '0;
            en_q       <= '0;
            shift_q    <= '0;
            phase_q    <= '0;
            bit_q      <= '0;
            cnt_q      <= '0;
            underrun_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            leds_q     <= leds_d;
            en_q       <= en_d;
            shift_q    <= shift_d;
            phase_q    <= phase_d;
            bit_q      <= bit_d;
            cnt_q      <= cnt_d;
            underrun_q <= underrun_d;
            done_q     <= done_d;
        end
    end

    // Lines are decoded from registered state only, so a reset drops them on the next edge.
    always_comb begin
        for (int c = 0; c < int'(NUM_CH); c++) begin
            data[c] = (state_q == StBit) && en_q[c] &&
                      (phase_q < (shift_q[c][BITS_PER_PIX-1] ? T1hCnt : T0hCnt));
        end
    end

    assign busy       = (state_q != StIdle);
    assign frame_done = done_q;
    assign underrun   = underrun_q;

endmodule
